// File: rtl/vga_kbd_pkg.sv
// vga_kbd_pkg: shared PS/2 receive state type, scan-code and ASCII constants.
package vga_kbd_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_BS    = 8'h08;
endpackage

// File: rtl/ps2_scan_to_ascii.sv
// ps2_scan_to_ascii: combinational set-2 make code to ASCII translation.
module ps2_scan_to_ascii
  import vga_kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       upper,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       valid
);
  logic [7:0]  let_c;
  logic [15:0] sym;
  always_comb begin
    let_c = 8'h00;
    case (code)
      8'h1C: let_c = "a";
      8'h32: let_c = "b";
      8'h21: let_c = "c";
      8'h23: let_c = "d";
      8'h24: let_c = "e";
      8'h2B: let_c = "f";
      8'h34: let_c = "g";
      8'h33: let_c = "h";
      8'h43: let_c = "i";
      8'h3B: let_c = "j";
      8'h42: let_c = "k";
      8'h4B: let_c = "l";
      8'h3A: let_c = "m";
      8'h31: let_c = "n";
      8'h44: let_c = "o";
      8'h4D: let_c = "p";
      8'h15: let_c = "q";
      8'h2D: let_c = "r";
      8'h1B: let_c = "s";
      8'h2C: let_c = "t";
      8'h3C: let_c = "u";
      8'h2A: let_c = "v";
      8'h1D: let_c = "w";
      8'h22: let_c = "x";
      8'h35: let_c = "y";
      8'h1A: let_c = "z";
      default: let_c = 8'h00;
    endcase
  end
  // Non-letters: upper byte unshifted, lower byte shifted
  always_comb begin
    sym = 16'h0000;
    case (code)
      8'h16: sym = "1!";
      8'h1E: sym = "2@";
      8'h26: sym = "3#";
      8'h25: sym = "4$";
      8'h2E: sym = "5%";
      8'h36: sym = "6^";
      8'h3D: sym = "7&";
      8'h3E: sym = "8*";
      8'h46: sym = "9(";
      8'h45: sym = "0)";
      8'h0E: sym = 16'h607E;
      8'h4E: sym = "-_";
      8'h55: sym = "=+";
      8'h54: sym = "[{";
      8'h5B: sym = "]}";
      8'h5D: sym = 16'h5C7C;
      8'h4C: sym = ";:";
      8'h52: sym = 16'h2722;
      8'h41: sym = ",<";
      8'h49: sym = ".>";
      8'h4A: sym = "/?";
      8'h29: sym = {ASC_SP, ASC_SP};
      8'h5A: sym = {ASC_CR, ASC_CR};
      8'h66: sym = {ASC_BS, ASC_BS};
      default: sym = 16'h0000;
    endcase
  end
  assign valid = (let_c != 8'h00) || (sym != 16'h0000);
  assign ascii = (let_c != 8'h00) ? (upper ? (let_c ^ 8'h20) : let_c)
                                  : (shift ? sym[7:0] : sym[15:8]);
endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 frame receiver and scan-code decoder producing ASCII write strobes.
module ps2_keyboard
  import vga_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] DATA_OUT,
  output logic       WR_EN,
  output logic       FRAME_ERR
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [2:0]    pclk_q;
  logic [1:0]    pdat_q;
  rx_state_e     state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          byte_v_q, byte_v_d, err_q, err_d;
  logic          brk_q, brk_d, ext_q, ext_d, shl_q, shl_d, shr_q, shr_d, caps_q, caps_d;
  logic [7:0]    data_q, data_d;
  logic          wr_q, wr_d;
  logic          fall, bit_i, asc_v;
  logic [7:0]    asc;
  // pclk_q[1:0] synchronize, pclk_q[2] is the edge-detect history
  assign fall  = pclk_q[2] & ~pclk_q[1];
  assign bit_i = pdat_q[1];
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pclk_q   <= 3'b111;
      pdat_q   <= 2'b11;
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      tmo_q    <= '0;
      byte_v_q <= 1'b0;
      err_q    <= 1'b0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      shl_q    <= 1'b0;
      shr_q    <= 1'b0;
      caps_q   <= 1'b0;
      data_q   <= '0;
      wr_q     <= 1'b0;
    end else begin
      pclk_q   <= {pclk_q[1:0], PS2_CLK};
      pdat_q   <= {pdat_q[0], PS2_DATA};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      tmo_q    <= tmo_d;
      byte_v_q <= byte_v_d;
      err_q    <= err_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      shl_q    <= shl_d;
      shr_q    <= shr_d;
      caps_q   <= caps_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    byte_v_d = 1'b0;
    err_d    = 1'b0;
    tmo_d    = (fall || state_q == IDLE) ? '0 : tmo_q + 1'b1;
    if (fall) begin
      case (state_q)
        IDLE: begin
          state_d = bit_i ? IDLE : DATA;
          cnt_d   = '0;
        end
        DATA: begin
          sh_d    = {bit_i, sh_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          err_d   = ~^{sh_q, bit_i};
          state_d = err_d ? IDLE : STOP;
        end
        default: begin
          byte_v_d = bit_i;
          err_d    = ~bit_i;
          state_d  = IDLE;
        end
      endcase
    end else if (state_q != IDLE && tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end
  ps2_scan_to_ascii u_map (
    .code  (sh_q),
    .upper ((shl_q | shr_q) ^ caps_q),
    .shift (shl_q | shr_q),
    .ascii (asc),
    .valid (asc_v)
  );
  // sh_q holds the accepted byte until the next frame starts shifting
  always_comb begin
    brk_d  = brk_q;
    ext_d  = ext_q;
    shl_d  = shl_q;
    shr_d  = shr_q;
    caps_d = caps_q;
    data_d = data_q;
    wr_d   = 1'b0;
    if (byte_v_q) begin
      if (sh_q == SC_BRK) brk_d = 1'b1;
      else if (sh_q == SC_EXT) ext_d = 1'b1;
      else if (brk_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        shl_d = shl_q & (sh_q != SC_LSHIFT);
        shr_d = shr_q & (sh_q != SC_RSHIFT);
      end
      else if (ext_q) ext_d = 1'b0;
      else if (sh_q == SC_LSHIFT) shl_d = 1'b1;
      else if (sh_q == SC_RSHIFT) shr_d = 1'b1;
      else if (sh_q == SC_CAPS) caps_d = ~caps_q;
      else if (asc_v) begin
        wr_d   = 1'b1;
        data_d = asc;
      end
    end
  end
  assign DATA_OUT  = data_q;
  assign WR_EN     = wr_q;
  assign FRAME_ERR = err_q;
endmodule
